// File: rtl/ram_pkg.sv
// Shared constants and state type for the clearable RAM family (ram8_clr, ram64_clr).
package ram_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned RAM8_DEPTH  = 8;
  localparam int unsigned RAM8_ADDR_W = 3;

  typedef enum logic {
    IDLE,
    CLEARING
  } state_e;

endpackage

// File: rtl/ram8_clr_if.sv
// Bus bundle for ram8_clr: write data/enable, address, clear request and status.
interface ram8_clr_if;
  import ram_pkg::*;

  logic [WORD_W-1:0]      in;
  logic                   load;
  logic [RAM8_ADDR_W-1:0] address;
  logic                   clr;
  logic [WORD_W-1:0]      out;
  logic                   busy;
  logic                   done;

  modport master (
    output in,
    output load,
    output address,
    output clr,
    input  out,
    input  busy,
    input  done
  );

  modport slave (
    input  in,
    input  load,
    input  address,
    input  clr,
    output out,
    output busy,
    output done
  );

endinterface

// File: rtl/dmux8way.sv
// 1-to-8 demultiplexer; routes in_i to the one-hot output chosen by sel_i.
module dmux8way (
  input  logic       in_i,
  input  logic [2:0] sel_i,
  output logic [7:0] out_o
);

  // One-hot decode gated by in_i.
  always_comb begin
    out_o        = 8'h00;
    out_o[sel_i] = in_i;
  end

endmodule

// File: rtl/mux8way16.sv
// 8-way 16-bit read selector.
module mux8way16 (
  input  logic [7:0][15:0] in_i,
  input  logic [2:0]       sel_i,
  output logic [15:0]      out_o
);

  // Purely combinational word select.
  always_comb begin
    out_o = in_i[sel_i];
  end

endmodule

// File: rtl/register16.sv
// 16-bit register with load enable and asynchronous active-low reset.
module register16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q;

  // Capture d_i when loaded; cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 16'h0000;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ram8_clr.sv
// 8 x 16-bit register RAM with combinational read, edge write and a one-word-per-cycle
// hardware clear sweep reporting busy/done.
module ram8_clr
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned DEPTH  = RAM8_DEPTH,
  parameter int unsigned ADDR_W = RAM8_ADDR_W
) (
  input logic       clk,
  input logic       rst_n,
  ram8_clr_if.slave bus
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic                  clearing;
  logic                  wr_req;
  logic [DEPTH-1:0]      wr_en;
  logic [DEPTH-1:0]      clr_en;
  logic [WIDTH-1:0]      word_d;
  logic [DEPTH-1:0][WIDTH-1:0] words;
  logic [ADDR_W-1:0]     rd_addr;

  assign clearing = (state_q == CLEARING);
  // clr wins over load in the same IDLE cycle; writes are dropped while sweeping.
  assign wr_req   = (state_q == IDLE) && bus.load && !bus.clr;
  assign word_d   = clearing ? '0 : bus.in;
  assign rd_addr  = bus.address;

  // Sweep sequencer: next state, counter and done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        // Counter wraps 7 -> 0 on the final edge, leaving it ready for the next sweep.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  dmux8way u_wr_dec (
    .in_i  (wr_req),
    .sel_i (rd_addr),
    .out_o (wr_en)
  );

  dmux8way u_clr_dec (
    .in_i  (clearing),
    .sel_i (cnt_q),
    .out_o (clr_en)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    register16 u_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (wr_en[i] | clr_en[i]),
      .d_i    (word_d),
      .q_o    (words[i])
    );
  end

  mux8way16 u_rd_mux (
    .in_i  (words),
    .sel_i (rd_addr),
    .out_o (bus.out)
  );

  assign bus.busy = clearing;
  assign bus.done = done_q;

endmodule
